// File: rtl/watch_pkg.sv
// Shared constants for the watch mode sequencer: one-hot mode selects,
// their binary indices, and the mode state type.
package watch_pkg;

    localparam int NUM_MODES = 3;

    localparam logic [2:0] MODE_CLOCK     = 3'b001;
    localparam logic [2:0] MODE_STOPWATCH = 3'b010;
    localparam logic [2:0] MODE_ALARM     = 3'b100;

    localparam logic [1:0] IDX_CLOCK     = 2'd0;
    localparam logic [1:0] IDX_STOPWATCH = 2'd1;
    localparam logic [1:0] IDX_ALARM     = 2'd2;

    // State encodings equal the one-hot mux selects, so the state register
    // drives the HEX/key mux directly.
    typedef enum logic [2:0] {
        ST_CLOCK     = MODE_CLOCK,
        ST_STOPWATCH = MODE_STOPWATCH,
        ST_ALARM     = MODE_ALARM
    } mode_e;

    function automatic logic [1:0] mode_to_idx(input logic [2:0] mode);
        case (mode)
            MODE_STOPWATCH: return IDX_STOPWATCH;
            MODE_ALARM:     return IDX_ALARM;
            default:        return IDX_CLOCK;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted press (debounced 1->0). Releases are
// debounced the same way but produce no pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam logic [19:0] CNT_TC = 20'(DEBOUNCE_CYCLES - 1);

    logic        sync1_q, sync2_q;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic [19:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronized key differs from the
    // accepted level; accept it once the count hits terminal.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_TC) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    // Synchronizer, debounced level, counter and pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch mode sequencer: CLOCK -> STOPWATCH -> ALARM -> CLOCK on each
// debounced mode press, blocked while the active sub-block is editing.
// Optional idle auto-return to CLOCK: define WATCH_MODE_AUTORETURN_EN.
//
//   state        | meaning
//   ST_CLOCK     | time display, keys routed to clock block
//   ST_STOPWATCH | stopwatch display, keys routed to stopwatch block
//   ST_ALARM     | alarm display, keys routed to alarm block
module watch_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_SEC     = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic [2:0] key_act_n,
    input  logic       busy,
    input  logic       tick_1hz,
    output logic [2:0] mux_mode,
    output logic [1:0] mode_idx,
    output logic       mode_changed,
    output logic       mode_press
);
    import watch_pkg::*;

    mode_e state_q, state_d;
    logic  changed_q, changed_d;
    logic  press;
    logic  advance;
    logic  timeout;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_mode (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n_i(key_mode_n),
        .press_o(press)
    );

    assign advance = press & ~busy;

`ifdef WATCH_MODE_AUTORETURN_EN
    logic [2:0] act_s1_q, act_s2_q;
    logic [7:0] idle_q, idle_d;

    assign timeout = (idle_q == 8'(TIMEOUT_SEC));

    // Idle seconds outside CLOCK; any user or sub-block activity restarts it.
    always_comb begin
        idle_d = idle_q;
        if (!(&act_s2_q) || press || busy || timeout ||
            (state_d != state_q) || (state_q == ST_CLOCK)) begin
            idle_d = '0;
        end else if (tick_1hz) begin
            idle_d = idle_q + 8'd1;
        end
    end

    // Activity-key synchronizers and idle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_s1_q <= 3'b111;
            act_s2_q <= 3'b111;
            idle_q   <= '0;
        end else begin
            act_s1_q <= key_act_n;
            act_s2_q <= act_s1_q;
            idle_q   <= idle_d;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = tick_1hz ^ (^key_act_n);
    assign timeout       = 1'b0;
`endif

    // Next mode: advance on an unblocked press; a press outranks timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLOCK:     if (advance) state_d = ST_STOPWATCH;
            ST_STOPWATCH: if (advance) state_d = ST_ALARM;
            ST_ALARM:     if (advance) state_d = ST_CLOCK;
            default:      state_d = ST_CLOCK;
        endcase
        if (timeout && !press) begin
            state_d = ST_CLOCK;
        end
        changed_d = (state_d != state_q);
    end

    // Mode register and change strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLOCK;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            changed_q <= changed_d;
        end
    end

    assign mux_mode     = state_q;
    assign mode_idx     = mode_to_idx(state_q);
    assign mode_changed = changed_q;
    assign mode_press   = press;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed bench for watch_mode_ctrl with DEBOUNCE_CYCLES=4, TIMEOUT_SEC=3.
module tb_watch_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_mode_n;
    logic [2:0] key_act_n;
    logic       busy;
    logic       tick_1hz;
    logic [2:0] mux_mode;
    logic [1:0] mode_idx;
    logic       mode_changed;
    logic       mode_press;

    int pass_cnt = 0;
    int total    = 0;

    watch_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_SEC    (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_mode_n  (key_mode_n),
        .key_act_n   (key_act_n),
        .busy        (busy),
        .tick_1hz    (tick_1hz),
        .mux_mode    (mux_mode),
        .mode_idx    (mode_idx),
        .mode_changed(mode_changed),
        .mode_press  (mode_press)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Hold the key low until a press pulse (bounded), sample mode_changed on
    // the following cycle, then release and let the release debounce settle.
    task automatic press_key(output bit seen, output bit chg);
        seen = 1'b0;
        chg  = 1'b0;
        key_mode_n = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mode_press) seen = 1'b1;
        end
        @(negedge clk);
        chg = mode_changed;
        key_mode_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic count_presses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (mode_press) n++;
        end
    endtask

    task automatic tick_once();
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit seen, chg;
        int n, lat;
        logic [2:0] exp_seq [3];
        logic [1:0] exp_idx [3];
        exp_seq[0] = 3'b010; exp_seq[1] = 3'b100; exp_seq[2] = 3'b001;
        exp_idx[0] = 2'd1;   exp_idx[1] = 2'd2;   exp_idx[2] = 2'd0;

        rst_n = 1'b0; key_mode_n = 1'b1; key_act_n = 3'b111;
        busy = 1'b0; tick_1hz = 1'b0;

        // 1: reset values after the first reset edge
        @(negedge clk);
        check("rst_mux", mux_mode, 3'b001);
        check("rst_idx", mode_idx, 2'd0);
        check("rst_chg", mode_changed, 1'b0);
        check("rst_press", mode_press, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: long hold -> single press, latency 2 sync + 4 debounce
        key_mode_n = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(negedge clk);
            if (mode_press) lat = i;
        end
        check("press_latency_ok", (lat >= 5 && lat <= 7), 1'b1);
        check("mux_before_update", mux_mode, 3'b001);
        @(negedge clk);
        check("mux_after_press", mux_mode, 3'b010);
        check("idx_after_press", mode_idx, 2'd1);
        check("chg_pulse", mode_changed, 1'b1);
        check("press_one_cycle", mode_press, 1'b0);
        @(negedge clk);
        check("chg_cleared", mode_changed, 1'b0);
        count_presses(12, n);
        check("hold_no_repress", n, 0);
        key_mode_n = 1'b1;
        count_presses(12, n);
        check("release_no_press", n, 0);
        check("mux_after_release", mux_mode, 3'b010);

        // 3: three presses from reset walk the full ring
        do_reset();
        check("rst2_mux", mux_mode, 3'b001);
        for (int k = 0; k < 3; k++) begin
            press_key(seen, chg);
            check("seq_seen", seen, 1'b1);
            check("seq_chg", chg, 1'b1);
            check("seq_mux", mux_mode, exp_seq[k]);
            check("seq_idx", mode_idx, exp_idx[k]);
        end

        // 4a: 3-cycle glitch is rejected
        key_mode_n = 1'b0;
        repeat (3) @(negedge clk);
        key_mode_n = 1'b1;
        count_presses(12, n);
        check("glitch3_no_press", n, 0);
        check("glitch3_mux", mux_mode, 3'b001);

        // 4b: 4-cycle low is exactly long enough to be accepted
        key_mode_n = 1'b0;
        repeat (4) @(negedge clk);
        key_mode_n = 1'b1;
        count_presses(14, n);
        check("pulse4_press", n, 1);
        check("pulse4_mux", mux_mode, 3'b010);

        // 4c: press while busy is reported but dropped
        busy = 1'b1;
        press_key(seen, chg);
        busy = 1'b0;
        check("busy_seen", seen, 1'b1);
        check("busy_no_chg", chg, 1'b0);
        check("busy_mux", mux_mode, 3'b010);
        repeat (4) @(negedge clk);
        check("busy_not_queued", mux_mode, 3'b010);

`ifdef WATCH_MODE_AUTORETURN_EN
        // 5: idle timeout in STOPWATCH, restarted by activity key
        tick_once(); @(negedge clk);
        tick_once(); @(negedge clk);
        check("idle2_mux", mux_mode, 3'b010);
        key_act_n = 3'b101;
        repeat (3) @(negedge clk);
        key_act_n = 3'b111;
        repeat (3) @(negedge clk);
        tick_once(); @(negedge clk);
        tick_once(); @(negedge clk);
        check("restart_mux", mux_mode, 3'b010);
        tick_once();
        check("timeout_mux", mux_mode, 3'b001);
        check("timeout_chg", mode_changed, 1'b1);
        @(negedge clk);
        check("timeout_chg_clear", mode_changed, 1'b0);
`else
        // 5: without auto-return, ticks never change the mode
        for (int k = 0; k < 5; k++) begin
            tick_once(); @(negedge clk);
        end
        check("no_autoret_mux", mux_mode, 3'b010);
`endif

        // 6: reset mid-debounce while in ALARM
        for (int k = 0; k < 3 && mux_mode !== 3'b100; k++) press_key(seen, chg);
        check("reach_alarm", mux_mode, 3'b100);
        key_mode_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        key_mode_n = 1'b1;
        @(negedge clk);
        check("midrst_mux", mux_mode, 3'b001);
        check("midrst_idx", mode_idx, 2'd0);
        check("midrst_press", mode_press, 1'b0);
        rst_n = 1'b1;
        count_presses(12, n);
        check("midrst_no_pulse", n, 0);
        check("midrst_mux_hold", mux_mode, 3'b001);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
